dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 60 ++++++
 rtl/dmem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles every handshake and bus signal of the data-memory arbiter.
//   The two requesters (0 = core, 1 = host loader) and the memory sit on
//   the master side. The arbiter sits on the slave side.
//
//   Requester n signals:
//     reqn    access request (level-sensitive)
//     wen     1 = write, 0 = read
//     addrn   access address
//     wdatan  write data
//     gntn    one-cycle grant pulse
//     donen   one-cycle completion pulse
//   Shared / memory signals:
//     rdata      read data, valid while donen is high
//     mem_addr   memory address
//     mem_wdata  memory write data
//     mem_we     memory write strobe
//     mem_rdata  memory read data
//     busy       arbiter is not idle
interface dmem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, done0, gnt1, done1,
        output rdata, mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, done0, gnt1, done1,
        input  rdata, mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter in front of a single-port data memory. One access
//   is in flight at a time: IDLE -> GRANT -> (WAIT) -> DONE -> IDLE.
//   Every output is a register, so no request input reaches an output
//   through combinational logic.
//
//   Ports:
//     clock  single clock, all state on the rising edge
//     reset  synchronous, active-high
//     bus    dmem_arbiter_if.slave (requesters, shared read data, memory)
//
//   Parameters:
//     DATA_W   data bus width
//     ADDR_W   memory address width
//     MEM_LAT  memory read latency in cycles (1..4)
//
//   Build option:
//     DMEM_ARB_RR_EN  defined   -> round-robin on ties
//                     undefined -> fixed priority, core (0) wins ties
module dmem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              winner_q, winner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic anyReq;
    logic pickWinner;

`ifdef DMEM_ARB_RR_EN
    logic rr_q, rr_d;
`endif

    // Winner selection while idle. A lone requester always wins; only a
    // tie consults the priority scheme.
    assign anyReq = bus.req0 | bus.req1;
`ifdef DMEM_ARB_RR_EN
    assign pickWinner = (bus.req0 && bus.req1) ? rr_q : bus.req1;
`else
    assign pickWinner = ~bus.req0;
`endif

    // Next-state logic. The latency counter also counts down through
    // GRANT, so a read spends MEM_LAT-1 cycles in WAIT. With MEM_LAT = 1
    // the read skips WAIT and finishes like a write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d = GRANT;
                    cnt_d   = 2'(MEM_LAT - 1);
                end
            end
            GRANT: begin
                if (we_q || cnt_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = cnt_q - 2'd1;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the latched request.
    // Pulses default low, and held values default to their current value.
    always_comb begin
        winner_d    = winner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata_d     = rdata_q;
        busy_d      = (state_d != IDLE);
`ifdef DMEM_ARB_RR_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    winner_d    = pickWinner;
                    we_d        = pickWinner ? bus.we1    : bus.we0;
                    mem_addr_d  = pickWinner ? bus.addr1  : bus.addr0;
                    mem_wdata_d = pickWinner ? bus.wdata1 : bus.wdata0;
                    mem_we_d    = pickWinner ? bus.we1    : bus.we0;
                    gnt0_d      = ~pickWinner;
                    gnt1_d      = pickWinner;
                end
            end
            GRANT, WAIT: begin
                if (state_d == DONE) begin
                    done0_d = ~winner_q;
                    done1_d = winner_q;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
`ifdef DMEM_ARB_RR_EN
                rr_d = ~winner_q;
`endif
            end
            default: begin
            end
        endcase
    end

    // State register. A reset aborts any access in flight without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            winner_q    <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            winner_q    <= winner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a combinational memory model.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmem_arbiter;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int MEM_LAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // The memory returns a fixed word at 0x0020 and a scrambled address elsewhere.
    function automatic logic [15:0] memModel(input logic [15:0] a);
        return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    assign bus.mem_rdata = memModel(bus.mem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        if (port == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    // Count cycles from the grant cycle until the done pulse, bounded.
    task automatic waitDone(input int which, output int lat);
        lat = 0;
        while (((which == 0) ? bus.done0 : bus.done1) !== 1'b1 && lat < 20) begin
            nextCycle;
            lat++;
        end
    endtask

    // The two requesters never get a grant or done pulse in the same cycle,
    // and the write strobe only appears alongside a grant.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("gntOverlap", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            checkOutput("doneOverlap", 32'(bus.done0 & bus.done1), 32'd0);
            checkOutput("memWeNoGnt", 32'(bus.mem_we & ~(bus.gnt0 | bus.gnt1)), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int g;
        int doneAt;
        int gntAt;
        logic [3:0] seq;
        logic [3:0] expSeq;

        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
        reset = 1'b1;
        nextCycle;

        // A request raised during the last reset cycle is not sampled by that edge.
        applyStimulus(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        nextCycle;
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetGnt0", 32'(bus.gnt0), 32'd0);
        checkOutput("resetGnt1", 32'(bus.gnt1), 32'd0);
        checkOutput("resetDone0", 32'(bus.done0), 32'd0);
        checkOutput("resetDone1", 32'(bus.done1), 32'd0);
        checkOutput("resetMemWe", 32'(bus.mem_we), 32'd0);
        checkOutput("resetMemAddr", 32'(bus.mem_addr), 32'd0);
        checkOutput("resetMemWdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("resetRdata", 32'(bus.rdata), 32'd0);
        reset = 1'b0;

        // Single write from the core.
        nextCycle;
        checkOutput("wrGnt0", 32'(bus.gnt0), 32'd1);
        checkOutput("wrGnt1", 32'(bus.gnt1), 32'd0);
        checkOutput("wrMemWe", 32'(bus.mem_we), 32'd1);
        checkOutput("wrMemAddr", 32'(bus.mem_addr), 32'h0010);
        checkOutput("wrMemWdata", 32'(bus.mem_wdata), 32'hBEEF);
        checkOutput("wrBusyGnt", 32'(bus.busy), 32'd1);
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        nextCycle;
        checkOutput("wrDone0", 32'(bus.done0), 32'd1);
        checkOutput("wrGnt0Low", 32'(bus.gnt0), 32'd0);
        checkOutput("wrMemWeLow", 32'(bus.mem_we), 32'd0);
        checkOutput("wrBusyDone", 32'(bus.busy), 32'd1);
        nextCycle;
        checkOutput("wrDone0Low", 32'(bus.done0), 32'd0);
        checkOutput("wrBusyIdle", 32'(bus.busy), 32'd0);

        // Read from the host loader.
        applyStimulus(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        nextCycle;
        checkOutput("rdGnt1", 32'(bus.gnt1), 32'd1);
        checkOutput("rdMemWe", 32'(bus.mem_we), 32'd0);
        checkOutput("rdMemAddr", 32'(bus.mem_addr), 32'h0020);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
        waitDone(1, lat);
        checkOutput("rdLatency", 32'(lat), 32'(MEM_LAT));
        checkOutput("rdData", 32'(bus.rdata), 32'h1234);
        nextCycle;
        checkOutput("rdDone1Low", 32'(bus.done1), 32'd0);
        checkOutput("rdDataHeld", 32'(bus.rdata), 32'h1234);
        checkOutput("rdBusyIdle", 32'(bus.busy), 32'd0);

        // A write leaves the last read data untouched.
        applyStimulus(1, 1'b1, 1'b1, 16'h0021, 16'h5555);
        nextCycle;
        checkOutput("wr1Gnt1", 32'(bus.gnt1), 32'd1);
        checkOutput("wr1MemWe", 32'(bus.mem_we), 32'd1);
        checkOutput("wr1MemWdata", 32'(bus.mem_wdata), 32'h5555);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
        nextCycle;
        checkOutput("wr1Done1", 32'(bus.done1), 32'd1);
        checkOutput("rdataAfterWrite", 32'(bus.rdata), 32'h1234);
        nextCycle;

        // Both requesters hold read requests for four accesses.
        applyStimulus(0, 1'b1, 1'b0, 16'h0030, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 16'h0040, 16'h0);
        g = 0;
        seq = 4'b0000;
        for (int c = 0; c < 60; c++) begin
            nextCycle;
            if (bus.gnt0 || bus.gnt1) begin
                if (g < 4) seq[g] = bus.gnt1;
                g++;
                if (g == 4) begin
                    applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
                    applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
            if (bus.done0 || bus.done1) begin
                checkOutput("tieRdata", 32'(bus.rdata), 32'(memModel(bus.done1 ? 16'h0040 : 16'h0030)));
            end
            if (g >= 4 && !bus.busy) break;
        end
`ifdef DMEM_ARB_RR_EN
        expSeq = 4'b1010;
`else
        expSeq = 4'b0000;
`endif
        checkOutput("tieGrantCount", 32'(g), 32'd4);
        checkOutput("tieGrantSeq", 32'(seq), 32'(expSeq));
        checkOutput("tieBusyIdle", 32'(bus.busy), 32'd0);

        // Reset in the middle of a read: no done pulse, and a new read completes.
        applyStimulus(0, 1'b1, 1'b0, 16'h0050, 16'h0);
        nextCycle;
        checkOutput("abGnt0", 32'(bus.gnt0), 32'd1);
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        nextCycle;
        checkOutput("abInWaitBusy", 32'(bus.busy), 32'd1);
        checkOutput("abInWaitDone0", 32'(bus.done0), 32'd0);
        reset = 1'b1;
        nextCycle;
        checkOutput("abBusy", 32'(bus.busy), 32'd0);
        checkOutput("abDone0", 32'(bus.done0), 32'd0);
        checkOutput("abRdata", 32'(bus.rdata), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nextCycle;
            checkOutput("abNoDone0", 32'(bus.done0), 32'd0);
            checkOutput("abStayIdle", 32'(bus.busy), 32'd0);
        end
        applyStimulus(0, 1'b1, 1'b0, 16'h0020, 16'h0);
        nextCycle;
        checkOutput("abNewGnt0", 32'(bus.gnt0), 32'd1);
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        waitDone(0, lat);
        checkOutput("abNewLatency", 32'(lat), 32'(MEM_LAT));
        checkOutput("abNewRdata", 32'(bus.rdata), 32'h1234);
        nextCycle;

        // A late request from the loader waits for the core's access to finish.
        applyStimulus(0, 1'b1, 1'b0, 16'h0060, 16'h0);
        nextCycle;
        checkOutput("lateGnt0", 32'(bus.gnt0), 32'd1);
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        nextCycle;
        applyStimulus(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        doneAt = -1;
        gntAt  = -1;
        for (int c = 1; c <= 20; c++) begin
            nextCycle;
            if (bus.done0) begin
                doneAt = c;
                checkOutput("lateRdata0", 32'(bus.rdata), 32'(memModel(16'h0060)));
            end
            if (bus.gnt1) begin
                gntAt = c;
                applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
                break;
            end
        end
        checkOutput("lateDone0Seen", 32'(doneAt > 0), 32'd1);
        checkOutput("lateGnt1Gap", 32'(gntAt - doneAt), 32'd2);
        waitDone(1, lat);
        checkOutput("lateLatency", 32'(lat), 32'(MEM_LAT));
        checkOutput("lateRdata1", 32'(bus.rdata), 32'h1234);
        nextCycle;
        checkOutput("lateBusyIdle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
